// File: rtl/mul_16x16_signed.sv
// Pipelined ASIZE x BSIZE multiplier with per-operand signedness, 3-cycle latency.
// Operands are split into low/high halves; four half-products are summed over two stages.
module mul_16x16_signed #(
  parameter  int ASIZE    = 16,
  parameter  int BSIZE    = 16,
  parameter  int A_SIGNED = 1,
  parameter  int B_SIGNED = 1,
  localparam int PSIZE    = ASIZE + BSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [ASIZE-1:0] a,
  input  logic [BSIZE-1:0] b,
  output logic [PSIZE-1:0] p
);

  localparam int AL = ASIZE / 2;
  localparam int AH = ASIZE - AL;
  localparam int BL = BSIZE / 2;
  localparam int BH = BSIZE - BL;
  // Each half gets one extra bit so every partial is a plain signed multiply:
  // low halves are zero-extended, high halves carry the operand sign (or 0 if unsigned).
  localparam int KA = AH + 1;
  localparam int KB = BH + 1;
  localparam int KP = KA + KB;

  logic             a_sign, b_sign;
  logic [KA-1:0]    a_lo_x, a_hi_x;
  logic [KB-1:0]    b_lo_x, b_hi_x;

  logic [KP-1:0]    pp_ll_d, pp_ll_q;
  logic [KP-1:0]    pp_lh_d, pp_lh_q;
  logic [KP-1:0]    pp_hl_d, pp_hl_q;
  logic [KP-1:0]    pp_hh_d, pp_hh_q;
  logic [PSIZE-1:0] sum_lo_d, sum_lo_q;
  logic [PSIZE-1:0] sum_hi_d, sum_hi_q;
  logic [PSIZE-1:0] p_d, p_q;

  function automatic logic [KP-1:0] ext_a(input logic [KA-1:0] x);
    return {{KB{x[KA-1]}}, x};
  endfunction

  function automatic logic [KP-1:0] ext_b(input logic [KB-1:0] x);
    return {{KA{x[KB-1]}}, x};
  endfunction

  function automatic logic [PSIZE-1:0] ext_p(input logic [KP-1:0] x);
    return {{(PSIZE-KP){x[KP-1]}}, x};
  endfunction

  always_comb begin
    a_sign = (A_SIGNED != 0) && a[ASIZE-1];
    b_sign = (B_SIGNED != 0) && b[BSIZE-1];
    a_lo_x = {{(KA-AL){1'b0}}, a[AL-1:0]};
    a_hi_x = {a_sign, a[ASIZE-1:AL]};
    b_lo_x = {{(KB-BL){1'b0}}, b[BL-1:0]};
    b_hi_x = {b_sign, b[BSIZE-1:BL]};
  end

  always_comb begin
    pp_ll_d = pp_ll_q;
    pp_lh_d = pp_lh_q;
    pp_hl_d = pp_hl_q;
    pp_hh_d = pp_hh_q;
    if (ce) begin
      pp_ll_d = $signed(ext_a(a_lo_x)) * $signed(ext_b(b_lo_x));
      pp_lh_d = $signed(ext_a(a_lo_x)) * $signed(ext_b(b_hi_x));
      pp_hl_d = $signed(ext_a(a_hi_x)) * $signed(ext_b(b_lo_x));
      pp_hh_d = $signed(ext_a(a_hi_x)) * $signed(ext_b(b_hi_x));
    end
  end

  // Partials are weighted by their half offsets; modular PSIZE arithmetic gives the exact product.
  always_comb begin
    sum_lo_d = sum_lo_q;
    sum_hi_d = sum_hi_q;
    p_d      = p_q;
    if (ce) begin
      sum_lo_d = ext_p(pp_ll_q) + (ext_p(pp_lh_q) << BL);
      sum_hi_d = (ext_p(pp_hl_q) << AL) + (ext_p(pp_hh_q) << (AL + BL));
      p_d      = sum_lo_q + sum_hi_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_ll_q  <= '0;
      pp_lh_q  <= '0;
      pp_hl_q  <= '0;
      pp_hh_q  <= '0;
      sum_lo_q <= '0;
      sum_hi_q <= '0;
      p_q      <= '0;
    end else begin
      pp_ll_q  <= pp_ll_d;
      pp_lh_q  <= pp_lh_d;
      pp_hl_q  <= pp_hl_d;
      pp_hh_q  <= pp_hh_d;
      sum_lo_q <= sum_lo_d;
      sum_hi_q <= sum_hi_d;
      p_q      <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_mul_16x16_signed.sv
// Self-checking bench for mul_16x16_signed: delayed golden-product model plus directed literals.
module tb_mul_16x16_signed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b1;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;
  logic [31:0] p;

  int checks = 0;
  int errors = 0;

  logic [31:0] hist [3];

  localparam int NV = 9;
  logic [15:0] va [NV];
  logic [15:0] vb [NV];
  logic [31:0] vp [NV];

  always #5 clk = ~clk;

  mul_16x16_signed #(
    .ASIZE(16),
    .BSIZE(16),
    .A_SIGNED(1),
    .B_SIGNED(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .a  (a),
    .b  (b),
    .p  (p)
  );

  function automatic logic [31:0] golden(input logic [15:0] x, input logic [15:0] y);
    longint xs, ys;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    return 32'(xs * ys);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Three-deep delay of the exact product, advanced only on enabled edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist[0] <= '0;
      hist[1] <= '0;
      hist[2] <= '0;
    end else if (ce) begin
      hist[0] <= golden(a, b);
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  always @(negedge clk) check("model", p, hist[2]);

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] frozen;
    int k;

    va = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 16'h0002, 16'h0003, 16'hFFFF, 16'h7FFF};
    vb = '{16'h7FFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h1234, 16'hFFFE, 16'hFFFB, 16'hFFFF, 16'h8000};
    vp = '{32'h3FFF0001, 32'h40000000, 32'hFFFFFFFF, 32'hC0008000, 32'h00000000,
           32'hFFFFFFFC, 32'hFFFFFFF1, 32'h00000001, 32'hC0008000};

    // Reset held with live random operands.
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("reset_hold", p, 32'h0);
      a = 16'($urandom);
      b = 16'($urandom);
    end

    // Release reset and stream corner vectors back to back.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NV + 3; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1 || i == 2) check("post_reset_zero", p, 32'h0);
      if (i >= 3) check($sformatf("vec%0d", i - 3), p, vp[i - 3]);
      if (i < NV) begin
        a = va[i];
        b = vb[i];
      end else begin
        a = '0;
        b = '0;
      end
    end

    // Clock enable dropped for 4 cycles; product stream is 16*k in order.
    k = 1;
    frozen = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 6) check("ce_before", p, 32'(16 * (c - 2)));
      if (c == 6) frozen = p;
      if (c >= 7 && c <= 10) check("ce_frozen", p, frozen);
      if (c >= 11) check("ce_resume", p, 32'(16 * (c - 6)));
      if (c >= 6 && c <= 9) begin
        ce = 1'b0;
        a  = 16'($urandom);
        b  = 16'($urandom);
      end else begin
        ce = 1'b1;
        a  = 16'(k);
        b  = 16'h0010;
        k++;
      end
    end

    // Asynchronous reset pulse between edges with products in flight.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a = 16'h0100 + 16'(c);
      b = 16'h0003;
    end
    @(negedge clk);
    a = 16'h0009;
    b = 16'hFFFF;
    #2 rst = 1'b1;
    #1 check("async_rst", p, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_flush1", p, 32'h0);
    a = 16'h0002;
    b = 16'h0002;
    @(negedge clk);
    check("rst_flush2", p, 32'h0);
    a = '0;
    b = '0;
    @(negedge clk);
    check("rst_first", p, 32'hFFFFFFF7);
    @(negedge clk);
    check("rst_second", p, 32'h00000004);

    // Random soak with occasional clock-enable gaps.
    repeat (5000) begin
      @(negedge clk);
      a  = 16'($urandom);
      b  = 16'($urandom);
      ce = ($urandom_range(0, 7) != 0);
    end
    @(negedge clk);
    ce = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
